// File: rtl/inst_loader_if.sv
// Loader bus: UART byte stream in, instruction-memory write port and fetch control out.
interface inst_loader_if #(
  parameter int unsigned INST_WIDTH     = 32,
  parameter int unsigned INST_MEM_WIDTH = 12
);
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    reload;
  logic [INST_WIDTH-1:0]   inst_in;
  logic                    we;
  logic                    reset_pc;
  logic                    load_stall;
  logic                    running;
  logic                    overflow_err;
  logic [INST_MEM_WIDTH:0] words_loaded;

  modport master (
    input  rx_data, rx_valid, reload,
    output inst_in, we, reset_pc, load_stall, running, overflow_err, words_loaded
  );

  modport slave (
    output rx_data, rx_valid, reload,
    input  inst_in, we, reset_pc, load_stall, running, overflow_err, words_loaded
  );
endinterface

// File: rtl/inst_loader.sv
// Boot loader: reads a 32-bit big-endian word count, then assembles big-endian
// instruction words from the UART byte stream and strobes them into instruction memory.
module inst_loader #(
  parameter int unsigned INST_WIDTH     = 32,
  parameter int unsigned INST_MEM_WIDTH = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  inst_loader_if.master bus
);
  localparam int unsigned BYTES = INST_WIDTH / 8;
  localparam int unsigned BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned IW    = (BIW > 2) ? BIW : 2;
  localparam int unsigned WLW   = INST_MEM_WIDTH + 1;
  localparam logic [WLW-1:0] CAP   = WLW'(1) << INST_MEM_WIDTH;
  localparam logic [32:0]    CAP33 = 33'(1) << INST_MEM_WIDTH;

  typedef enum logic [2:0] {CLEAR, HDR, BODY, START, RUN} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           seen_q, seen_d;
  logic                  done_q, done_d;
  logic [INST_WIDTH-1:0] word_q, word_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  we_q, we_d;
  logic [WLW-1:0]        wl_q, wl_d;
  logic                  ovf_q, ovf_d;
  logic                  reset_pc_q, reset_pc_d;
  logic                  stall_q, stall_d;
  logic                  running_q, running_d;
  logic [31:0]           hdr_n;
  logic [INST_WIDTH-1:0] word_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      idx_q      <= '0;
      cnt_q      <= '0;
      seen_q     <= '0;
      done_q     <= 1'b0;
      word_q     <= '0;
      inst_q     <= '0;
      we_q       <= 1'b0;
      wl_q       <= '0;
      ovf_q      <= 1'b0;
      reset_pc_q <= 1'b1;
      stall_q    <= 1'b1;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      done_q     <= done_d;
      word_q     <= word_d;
      inst_q     <= inst_d;
      we_q       <= we_d;
      wl_q       <= wl_d;
      ovf_q      <= ovf_d;
      reset_pc_q <= reset_pc_d;
      stall_q    <= stall_d;
      running_q  <= running_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    done_d  = done_q;
    word_d  = word_q;
    inst_d  = inst_q;
    we_d    = 1'b0;
    wl_d    = wl_q;
    ovf_d   = ovf_q;
    hdr_n   = 32'({cnt_q, bus.rx_data});
    word_n  = INST_WIDTH'({word_q, bus.rx_data});

    unique case (state_q)
      CLEAR: begin
        state_d = HDR;
        idx_d   = '0;
        cnt_d   = '0;
        seen_d  = '0;
        done_d  = 1'b0;
      end
      HDR: if (bus.rx_valid) begin
        cnt_d = hdr_n;
        if (idx_q == IW'(3)) begin
          idx_d   = '0;
          ovf_d   = {1'b0, hdr_n} > CAP33;
          state_d = (hdr_n == 32'd0) ? START : BODY;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      BODY: begin
        // The last written word leaves BODY only after its strobe cycle.
        if (done_q) begin
          state_d = START;
        end else if (bus.rx_valid) begin
          word_d = word_n;
          if (idx_q == IW'(BYTES - 1)) begin
            idx_d  = '0;
            seen_d = seen_q + 32'd1;
            if (wl_q < CAP) begin
              we_d   = 1'b1;
              inst_d = word_n;
              wl_d   = wl_q + WLW'(1);
            end
            if (seen_q + 32'd1 == cnt_q) begin
              if (wl_q < CAP) done_d = 1'b1;
              else            state_d = START;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      START: state_d = RUN;
      RUN: if (bus.reload) begin
        state_d = CLEAR;
        wl_d    = '0;
        ovf_d   = 1'b0;
      end
      default: state_d = CLEAR;
    endcase

    reset_pc_d = (state_d == CLEAR) || (state_d == START);
    running_d  = (state_d == RUN);
    stall_d    = (state_d != RUN) && !we_d;
  end

  assign bus.inst_in      = inst_q;
  assign bus.we           = we_q;
  assign bus.reset_pc     = reset_pc_q;
  assign bus.load_stall   = stall_q;
  assign bus.running      = running_q;
  assign bus.overflow_err = ovf_q;
  assign bus.words_loaded = wl_q;
endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader with a small (4-word) instruction memory.
module tb_inst_loader;
  localparam int unsigned MW  = 2;
  localparam int unsigned CAP = 1 << MW;

  typedef struct {
    logic [31:0] n;
    int          nw;
    bit          rl_mid;
    int          exp_wl;
    bit          exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  bit   prev_we = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] fix_q[$];

  inst_loader_if #(.INST_WIDTH(32), .INST_MEM_WIDTH(MW)) bus();

  inst_loader #(.INST_WIDTH(32), .INST_MEM_WIDTH(MW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle monitor: each strobe must carry the next expected word; stall drops only on strobes.
  always @(negedge clk) if (mon_en) begin
    chk("stall_rule", bus.load_stall, (!bus.running && !bus.we));
    if (bus.we === 1'b1) begin
      chk("we_adjacent", prev_we, 0);
      if (exp_q.size() == 0) chk("unexpected_we", 1, 0);
      else chk("inst_in", bus.inst_in, exp_q.pop_front());
    end
    prev_we = (bus.we === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] n, input int nw, input bit rl_mid);
    logic [31:0] w;
    int waited;
    for (int b = 3; b >= 0; b--) send_byte(8'(n >> (8 * b)));
    for (int k = 0; k < nw; k++) begin
      w = (fix_q.size() > 0) ? fix_q.pop_front() : 32'($urandom);
      if (k < CAP) exp_q.push_back(w);
      for (int b = 3; b >= 0; b--) begin
        if (rl_mid && k == 0 && b == 1) bus.reload = 1'b1;
        send_byte(8'(w >> (8 * b)));
        bus.reload = 1'b0;
      end
    end
    waited = 0;
    while (bus.reset_pc !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("start_reset_pc", bus.reset_pc, 1);
    @(negedge clk);
    chk("start_one_cycle", bus.reset_pc, 0);
    chk("running_after_load", bus.running, 1);
    chk("all_words_written", exp_q.size(), 0);
  endtask

  task automatic do_reload();
    bus.reload = 1'b1;
    @(negedge clk);
    bus.reload = 1'b0;
    chk("reload_running", bus.running, 0);
    chk("reload_reset_pc", bus.reset_pc, 1);
    chk("reload_ovf_clr", bus.overflow_err, 0);
    chk("reload_wl_clr", bus.words_loaded, 0);
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("clear_one_cycle", bus.reset_pc, 0);
  endtask

  initial begin
    vec_t vt[6];
    logic [31:0] w;
    vt[0] = '{n: 32'd2, nw: 2, rl_mid: 1'b0, exp_wl: 2, exp_ovf: 1'b0};
    vt[1] = '{n: 32'd0, nw: 0, rl_mid: 1'b0, exp_wl: 0, exp_ovf: 1'b0};
    vt[2] = '{n: 32'd5, nw: 5, rl_mid: 1'b0, exp_wl: 4, exp_ovf: 1'b1};
    vt[3] = '{n: 32'd4, nw: 4, rl_mid: 1'b1, exp_wl: 4, exp_ovf: 1'b0};
    vt[4] = '{n: 32'd1, nw: 1, rl_mid: 1'b0, exp_wl: 1, exp_ovf: 1'b0};
    vt[5] = '{n: 32'd3, nw: 3, rl_mid: 1'b1, exp_wl: 3, exp_ovf: 1'b0};
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.reload   = 1'b0;

    // Reset and release.
    repeat (3) @(negedge clk);
    chk("rst_reset_pc", bus.reset_pc, 1);
    chk("rst_stall", bus.load_stall, 1);
    chk("rst_running", bus.running, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_inst", bus.inst_in, 0);
    mon_en = 1'b1;
    reset_n = 1'b1;
    #1 chk("rel_reset_pc", bus.reset_pc, 1);
    @(negedge clk);
    chk("hdr_reset_pc", bus.reset_pc, 0);
    chk("hdr_stall", bus.load_stall, 1);
    chk("hdr_running", bus.running, 0);
    repeat (3) @(negedge clk);
    chk("hdr_idle_running", bus.running, 0);

    fix_q.push_back(32'h11223344);
    fix_q.push_back(32'hAABBCCDD);
    foreach (vt[i]) begin
      if (i > 0) do_reload();
      run_load(vt[i].n, vt[i].nw, vt[i].rl_mid);
      chk($sformatf("wl_v%0d", i), bus.words_loaded, vt[i].exp_wl);
      chk($sformatf("ovf_v%0d", i), bus.overflow_err, vt[i].exp_ovf);
      repeat (3) send_byte(8'($urandom));
      chk($sformatf("run_ignores_v%0d", i), bus.running, 1);
      chk($sformatf("run_wl_v%0d", i), bus.words_loaded, vt[i].exp_wl);
    end

    // Reset in the middle of a body, then a clean reload.
    do_reload();
    for (int b = 3; b >= 0; b--) send_byte((b == 0) ? 8'h03 : 8'h00);
    w = 32'($urandom);
    exp_q.push_back(w);
    for (int b = 3; b >= 0; b--) send_byte(8'(w >> (8 * b)));
    w = 32'($urandom);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    @(negedge clk);
    chk("mid_wl_pre", bus.words_loaded, 1);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_reset_pc", bus.reset_pc, 1);
    chk("mid_rst_stall", bus.load_stall, 1);
    chk("mid_rst_running", bus.running, 0);
    chk("mid_rst_we", bus.we, 0);
    chk("mid_rst_wl", bus.words_loaded, 0);
    chk("mid_rst_inst", bus.inst_in, 0);
    chk("mid_rst_ovf", bus.overflow_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_hdr_reset_pc", bus.reset_pc, 0);
    fix_q.push_back(32'hDEADBEEF);
    run_load(32'd1, 1, 1'b0);
    chk("deadbeef_wl", bus.words_loaded, 1);
    chk("deadbeef_ovf", bus.overflow_err, 0);
    chk("deadbeef_inst", bus.inst_in, 32'hDEADBEEF);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
